// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the scoreboarded register file: defaults, the zero register
// and small address helpers used by both the data array and the scoreboard.
package regfile_sb_pkg;
  localparam int          XLEN_DEF = 32;
  localparam int unsigned REG_ZERO = 0;

  // Low bit of field k in a packed per-port bus of w-bit fields.
  function automatic int pidx(input int k, input int w);
    return k * w;
  endfunction

  // Architectural, writable register: not x0 and inside a non-power-of-2 depth.
  function automatic logic addr_valid(input int unsigned a, input int unsigned nregs);
    return (a != REG_ZERO) && (a < nregs);
  endfunction
endpackage

// File: rtl/regfile_sb_if.sv
// Bus between decode/writeback/debug (master) and the register file (slave).
interface regfile_sb_if import regfile_sb_pkg::*; #(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_ready;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic                alloc_ok;
  logic                flush;
  logic [AW:0]         pend_cnt;
  logic [AW-1:0]       dbg_addr;
  logic [XLEN-1:0]     dbg_data;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush, dbg_addr,
    input  rd_data, rd_ready, alloc_ok, pend_cnt, dbg_data
  );
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush, dbg_addr,
    output rd_data, rd_ready, alloc_ok, pend_cnt, dbg_data
  );
endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one bit per register set by decode allocation, cleared by
// writeback, plus operand readiness, allocation acceptance and a running pending count.
module regfile_scoreboard import regfile_sb_pkg::*; #(
  parameter  int NREGS  = 32,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] i_rd_addr,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic              i_alloc_en,
  input  logic [AW-1:0]     i_alloc_addr,
  input  logic              i_flush,
  output logic [NRD-1:0]    o_rd_ready,
  output logic              o_alloc_ok,
  output logic [AW:0]       o_pend_cnt
);
  logic [NREGS-1:0]  r_pend;
  logic [AW:0]       r_cnt;
  logic [2**AW-1:0]  w_pend_ext;
  logic              w_wr_ok, w_wr_clr, w_wr_hit_alloc;
  logic [NRD-1:0]    w_rdy;

  // Widen to the full address space so out-of-range addresses read as never pending.
  always_comb begin
    w_pend_ext = '0;
    w_pend_ext[NREGS-1:0] = r_pend;
  end

  assign w_wr_ok        = i_wr_en && addr_valid(32'(i_wr_addr), NREGS);
  assign w_wr_clr       = w_wr_ok && w_pend_ext[i_wr_addr];
  assign w_wr_hit_alloc = i_wr_en && (i_wr_addr == i_alloc_addr);
  assign o_alloc_ok     = i_alloc_en && addr_valid(32'(i_alloc_addr), NREGS) && !i_flush &&
                          (!w_pend_ext[i_alloc_addr] || w_wr_hit_alloc);

  for (genvar k = 0; k < NRD; k++) begin : g_rdy
    logic [AW-1:0] w_a;
    assign w_a      = i_rd_addr[pidx(k, AW) +: AW];
    assign w_rdy[k] = !w_pend_ext[w_a] || ((BYPASS != 0) && i_wr_en && (i_wr_addr == w_a));
  end
  assign o_rd_ready = w_rdy;

  // Set after clear: a writeback racing a new allocation leaves the new producer pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else if (i_flush) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr_ok)    r_pend[i_wr_addr]    <= 1'b0;
      if (o_alloc_ok) r_pend[i_alloc_addr] <= 1'b1;
      r_cnt <= r_cnt + {{AW{1'b0}}, o_alloc_ok} - {{AW{1'b0}}, w_wr_clr};
    end
  end

  assign o_pend_cnt = r_cnt;
endmodule

// File: rtl/regfile_sb.sv
// Parametrised integer register file with optional write-through bypass and an
// integrated pending-write scoreboard for RAW/WAW hazard detection.
module regfile_sb import regfile_sb_pkg::*; #(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int NREGS  = 32,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_sb_if.slave  bus
);
  logic [XLEN-1:0]           r_regs [NREGS];
  logic [NRD-1:0][XLEN-1:0]  w_rd_data;

  // x0 is never written, so its reset value of zero is permanent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (bus.wr_en && addr_valid(32'(bus.wr_addr), NREGS)) begin
      r_regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] w_a;
    logic          w_ok, w_hit;
    assign w_a          = bus.rd_addr[pidx(k, AW) +: AW];
    assign w_ok         = addr_valid(32'(w_a), NREGS);
    assign w_hit        = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == w_a);
    assign w_rd_data[k] = !w_ok ? '0 : (w_hit ? bus.wr_data : r_regs[w_a]);
  end
  assign bus.rd_data = w_rd_data;

  assign bus.dbg_data = addr_valid(32'(bus.dbg_addr), NREGS) ? r_regs[bus.dbg_addr] : '0;

  regfile_scoreboard #(.NREGS(NREGS), .NRD(NRD), .BYPASS(BYPASS)) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rd_addr    (bus.rd_addr),
    .i_wr_en      (bus.wr_en),
    .i_wr_addr    (bus.wr_addr),
    .i_alloc_en   (bus.alloc_en),
    .i_alloc_addr (bus.alloc_addr),
    .i_flush      (bus.flush),
    .o_rd_ready   (bus.rd_ready),
    .o_alloc_ok   (bus.alloc_ok),
    .o_pend_cnt   (bus.pend_cnt)
  );
endmodule
